// File: rtl/diram_scan_reader_if.sv
// Bus between the membership-RAM scan reader and its neighbours:
// the scan request, the RAM read port and the aggregated results.
interface diram_scan_reader_if #(
    parameter int DW = 6,
    parameter int AW = 3,
    parameter int SW = 9
);
    logic          start;
    logic [AW-1:0] RADD;
    logic [DW-1:0] DOUT;
    logic          busy;
    logic          done;
    logic [DW-1:0] max_val;
    logic [AW-1:0] max_idx;
    logic [DW-1:0] min_val;
    logic [SW-1:0] sum_val;
    logic [DW-1:0] avg_val;

    // Scan reader side.
    modport master (
        input  start, DOUT,
        output RADD, busy, done, max_val, max_idx, min_val, sum_val, avg_val
    );

    // RAM / consumer side.
    modport slave (
        output start, DOUT,
        input  RADD, busy, done, max_val, max_idx, min_val, sum_val, avg_val
    );
endinterface

// File: rtl/diram_scan_reader.sv
// Read-side sequencer for the fuzzy membership RAM. A start pulse walks the
// read address over every entry, samples the asynchronous read data and
// reduces it to max / argmax / min / sum / mean. Results are published all
// at once on the edge that samples the last entry, so no partial value is
// ever visible.
module diram_scan_reader #(
    parameter int DW    = 6,
    parameter int AW    = 3,
    parameter int DEPTH = 8,
    parameter int SW    = 9
) (
    input  logic clk,
    input  logic reset,
    diram_scan_reader_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t        state_reg, state_next;
    logic [AW-1:0] idx_reg;

    // Working accumulators, only meaningful while scanning.
    logic [DW-1:0] wmax_reg, wmin_reg;
    logic [AW-1:0] widx_reg;
    logic [SW-1:0] wsum_reg;

    // Published results.
    logic [DW-1:0] max_val_reg, min_val_reg, avg_val_reg;
    logic [AW-1:0] max_idx_reg;
    logic [SW-1:0] sum_val_reg;

    // Accumulator values after folding in the current sample.
    logic [DW-1:0] max_upd, min_upd;
    logic [AW-1:0] idx_upd;
    logic [SW-1:0] sum_upd;
    logic          last_sample;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; start is only honoured from IDLE, never queued.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (bus.start) state_next = S_SCAN;
            S_SCAN:  if (last_sample) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Moore outputs: address is only driven off zero while scanning.
    always_comb begin
        bus.RADD = '0;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state_reg)
            S_SCAN: begin
                bus.RADD = idx_reg;
                bus.busy = 1'b1;
            end
            S_DONE:  bus.done = 1'b1;
            default: ;
        endcase
    end

    // Fold the current sample in; strict compares keep the lowest index on ties.
    always_comb begin
        last_sample = (idx_reg == LAST_IDX);
        sum_upd     = wsum_reg + SW'(bus.DOUT);
        max_upd     = wmax_reg;
        idx_upd     = widx_reg;
        min_upd     = wmin_reg;
        if (bus.DOUT > wmax_reg) begin
            max_upd = bus.DOUT;
            idx_upd = idx_reg;
        end
        if (bus.DOUT < wmin_reg) begin
            min_upd = bus.DOUT;
        end
    end

    // Index counter, accumulators and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_reg     <= '0;
            wmax_reg    <= '0;
            wmin_reg    <= '1;
            widx_reg    <= '0;
            wsum_reg    <= '0;
            max_val_reg <= '0;
            max_idx_reg <= '0;
            min_val_reg <= '0;
            sum_val_reg <= '0;
            avg_val_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.start) begin
                        idx_reg  <= '0;
                        wmax_reg <= '0;
                        wmin_reg <= '1;
                        widx_reg <= '0;
                        wsum_reg <= '0;
                    end
                end
                S_SCAN: begin
                    // Natural wrap brings idx back to 0 after the last entry.
                    idx_reg  <= idx_reg + 1'b1;
                    wmax_reg <= max_upd;
                    wmin_reg <= min_upd;
                    widx_reg <= idx_upd;
                    wsum_reg <= sum_upd;
                    if (last_sample) begin
                        max_val_reg <= max_upd;
                        max_idx_reg <= idx_upd;
                        min_val_reg <= min_upd;
                        sum_val_reg <= sum_upd;
                        avg_val_reg <= DW'(sum_upd >> AW);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.max_val = max_val_reg;
    assign bus.max_idx = max_idx_reg;
    assign bus.min_val = min_val_reg;
    assign bus.sum_val = sum_val_reg;
    assign bus.avg_val = avg_val_reg;

endmodule

// File: tb/tb_diram_scan_reader.sv
// Scoreboard bench for diram_scan_reader: each accepted start pushes its
// hand-computed result and expected done cycle; a monitor pops on done.
module tb_diram_scan_reader;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    diram_scan_reader_if bus ();

    diram_scan_reader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural 8x6 RAM: asynchronous read, synchronous write.
    logic [5:0] ram [0:7] = '{default: 6'd31};
    logic       we = 1'b0;
    logic [2:0] wa = 3'd0;
    logic [5:0] wd = 6'd0;
    always @(posedge clk) if (we) ram[wa] <= wd;
    assign bus.DOUT = ram[bus.RADD];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int mx; int mi; int mn; int sm; int av; int dc;
    } exp_t;
    exp_t sb [$];

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic push(input int mx, input int mi, input int mn,
                        input int sm, input int av, input int dc);
        exp_t e;
        e.mx = mx; e.mi = mi; e.mn = mn; e.sm = sm; e.av = av; e.dc = dc;
        sb.push_back(e);
    endtask

    // Monitor: every done pulse must match the oldest outstanding scan.
    always @(negedge clk) begin
        if (bus.done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0 cyc=%0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("scan done cyc=%0d max=%0d idx=%0d min=%0d sum=%0d avg=%0d",
                         cyc, bus.max_val, bus.max_idx, bus.min_val, bus.sum_val, bus.avg_val);
                chk("done_cycle", cyc, e.dc);
                chk("max_val", int'(bus.max_val), e.mx);
                chk("max_idx", int'(bus.max_idx), e.mi);
                chk("min_val", int'(bus.min_val), e.mn);
                chk("sum_val", int'(bus.sum_val), e.sm);
                chk("avg_val", int'(bus.avg_val), e.av);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(output int k);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        k = cyc;
    endtask

    task automatic load8(input int a0, input int a1, input int a2, input int a3,
                         input int a4, input int a5, input int a6, input int a7);
        int a [8];
        a = '{a0, a1, a2, a3, a4, a5, a6, a7};
        for (int i = 0; i < 8; i++) begin
            we = 1'b1;
            wa = 3'(i);
            wd = 6'(a[i]);
            tick();
        end
        we = 1'b0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_radd"}, int'(bus.RADD), 0);
        chk({tag, "_max"},  int'(bus.max_val), 0);
        chk({tag, "_idx"},  int'(bus.max_idx), 0);
        chk({tag, "_min"},  int'(bus.min_val), 0);
        chk({tag, "_sum"},  int'(bus.sum_val), 0);
        chk({tag, "_avg"},  int'(bus.avg_val), 0);
    endtask

    initial begin
        int k;
        bus.start = 1'b0;

        // Reset state.
        #1 reset = 1'b1;
        #1 chk_zero_outputs("reset");
        tick();
        tick();
        reset = 1'b0;

        // Power-up contents (all 31).
        do_start(k);
        push(31, 0, 31, 248, 31, k + 8);
        repeat (10) tick();

        // Mixed contents with a tie on 63; RADD walks 0..7.
        load8(5, 40, 12, 63, 0, 22, 63, 7);
        do_start(k);
        push(63, 3, 0, 212, 26, k + 8);
        for (int i = 0; i < 8; i++) begin
            chk("radd_step", int'(bus.RADD), i);
            chk("busy_scan", int'(bus.busy), 1);
            tick();
        end
        chk("busy_in_done", int'(bus.busy), 0);
        chk("done_high", int'(bus.done), 1);
        chk("radd_in_done", int'(bus.RADD), 0);
        repeat (3) tick();

        // Starts during SCAN and DONE are ignored.
        do_start(k);
        push(63, 3, 0, 212, 26, k + 8);
        repeat (2) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        chk("busy_in_done2", int'(bus.busy), 0);
        chk("done_high2", int'(bus.done), 1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (12) tick();
        chk("idle_after_ignored", int'(bus.busy), 0);

        // Reset mid-scan: immediate abort, no done.
        do_start(k);
        repeat (3) tick();
        chk("busy_before_abort", int'(bus.busy), 1);
        #2 reset = 1'b1;
        #1 chk_zero_outputs("abort");
        tick();
        reset = 1'b0;
        repeat (12) tick();
        do_start(k);
        push(63, 3, 0, 212, 26, k + 8);
        repeat (10) tick();

        // Writes during a scan: address 6 ahead of the scan, address 1 behind it.
        do_start(k);
        push(63, 3, 0, 199, 24, k + 8);
        repeat (2) tick();
        we = 1'b1; wa = 3'd6; wd = 6'd50;
        tick();
        we = 1'b0;
        tick();
        we = 1'b1; wa = 3'd1; wd = 6'd50;
        tick();
        we = 1'b0;
        repeat (6) tick();

        // Write to address 1 is now visible: 5,50,12,63,0,22,50,7.
        do_start(k);
        push(63, 3, 0, 209, 26, k + 8);
        repeat (10) tick();

        // All 63.
        load8(63, 63, 63, 63, 63, 63, 63, 63);
        do_start(k);
        push(63, 0, 63, 504, 63, k + 8);
        repeat (10) tick();

        // All 0.
        load8(0, 0, 0, 0, 0, 0, 0, 0);
        do_start(k);
        push(0, 0, 0, 0, 0, k + 8);
        repeat (10) tick();

        // start held high: one scan per IDLE visit, every 10 cycles.
        load8(10, 20, 30, 40, 50, 60, 5, 9);
        bus.start = 1'b1;
        tick();
        k = cyc;
        push(60, 5, 5, 224, 28, k + 8);
        push(60, 5, 5, 224, 28, k + 18);
        repeat (10) tick();
        bus.start = 1'b0;
        repeat (12) tick();

        chk("pending_scans", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/diram_scan_reader.md
Name: diram_scan_reader

Overview:
- Read-side sequencer for the 8-entry x 6-bit fuzzy membership RAM.
- On a start pulse it drives the RAM read address through all entries in order and samples the asynchronous read data.
- It aggregates the entries into max, argmax, min, sum and mean for the rule-evaluation and defuzzification stages.
- It exposes a busy flag so the RAM writer can hold off writes during a scan.

Parameters:
- DW, 6, membership value width; must match the RAM data width.
- AW, 3, RAM address width.
- DEPTH, 8, number of entries scanned; must equal 2**AW.
- SW, 9, sum width = DW + AW; holds up to 8*63 = 504.

Ports:
- clk  input  1  rising-edge clock, shared with the RAM.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a scan; honoured only in IDLE.
- RADD  output  AW  read address to the RAM.
- DOUT  input  DW  asynchronous read data from the RAM, valid in the same cycle as RADD.
- busy  output  1  high from the cycle after start is accepted until the last entry is sampled.
- done  output  1  one-cycle pulse; all result outputs are valid and stable from this cycle on.
- max_val  output  DW  largest entry.
- max_idx  output  AW  address of the largest entry.
- min_val  output  DW  smallest entry.
- sum_val  output  SW  unsigned sum of all entries.
- avg_val  output  DW  sum_val >> AW (truncating mean).

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- States: IDLE, SCAN, DONE. Registered FSM with a registered index counter idx[AW-1:0].
- Reset (asynchronous, immediate):
  - state=IDLE, idx=0, RADD=0, busy=0, done=0.
  - max_val=0, max_idx=0, min_val=0, sum_val=0, avg_val=0.
- IDLE:
  - RADD=0, busy=0.
  - start=1 at edge k: state=SCAN, idx=0, working accumulators cleared (wmax=0, wmin=all-ones, wsum=0, widx=0).
- SCAN:
  - RADD=idx combinationally; busy=1.
  - Each edge samples DOUT and updates the accumulators:
    - wsum += DOUT.
    - If DOUT > wmax (strictly greater): wmax=DOUT, widx=idx.
    - If DOUT < wmin (strictly less): wmin=DOUT.
  - idx increments by 1 each edge.
  - At the edge sampling idx=DEPTH-1: idx wraps to 0, state=DONE, and the result registers load from the final accumulator values, including that last sample.
- DONE:
  - done=1 for exactly one cycle; busy=0; RADD=0; then IDLE.
- Timing:
  - Start accepted at edge k → SCAN occupies cycles k+1 .. k+8 → done high in cycle k+9.
  - Next start is accepted at edge k+10 at the earliest.
- Ties: strict comparison, so the lowest index wins argmax.
- Results hold their value between scans; they change only on the DONE-entry edge.
- Partial results are never visible on the outputs.
- start while busy or in DONE: ignored, not queued.
- start held high continuously: one scan per IDLE visit, i.e. one scan every 10 cycles.
- RAM writes during a scan are not blocked by this block. Each entry is sampled in the cycle its address is presented. A write to an address already passed affects the next scan only; a write landing at the current address is seen after the write edge.
- Reset mid-scan:
  - Abort immediately; return to IDLE.
  - Result outputs return to 0; no done pulse is produced.
- Arithmetic: all unsigned; sum_val cannot overflow at SW=9.

Test Plan:
- Reset, then start with the RAM at power-up contents (all 31) → done at start+9, max_val=31, max_idx=0, min_val=31, sum_val=248, avg_val=31.
- RAM = {5,40,12,63,0,22,63,7}, start → max_val=63, max_idx=3 (tie with 6 resolved to lower index), min_val=0, sum_val=212, avg_val=26. RADD must step 0..7 in cycles start+1..start+8.
- Pulse start again at start+3 and start+9 during the scan → ignored. Exactly one done; busy low during the done cycle.
- Assert reset at start+4 → busy=0 and outputs 0 immediately. No done pulse. A following start gives the correct full-scan result.
- During a scan, write 50 to address 1 at start+5 and 50 to address 6 at start+3 → address 1 is not reflected (already passed); address 6 is read as 50. With the previous contents: max_val=63, max_idx=3, sum_val=199.
- All entries 63 → sum_val=504, avg_val=63, max_idx=0. All entries 0 → min_val=0, max_val=0, max_idx=0.
